// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN frame controller.
// Holds the frame FSM state type, the default frame size, watchdog limit and
// counter width, and the class code reported when the watchdog fires.
`timescale 1ns/1ps
package cnn_pkg;

  localparam int unsigned DefFramePixels = 784;     // 28x28 frame
  localparam int unsigned DefTimeout     = 100000;  // cycles from first pixel to result
  localparam int unsigned DefCw          = 20;      // cycle counter width

  localparam logic [3:0] TimeoutCode = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait
  } frame_state_e;

endpackage

// File: rtl/cnn_watchdog.sv
// Saturating frame cycle counter with timeout compare.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   i_start    : load the counter with 1 (first pixel of a frame accepted)
//   i_clear    : return the counter to 0 (frame finished or dropped)
//   i_run      : count this cycle (frame in progress)
//   o_count    : current cycle count
//   o_expired  : count has reached TIMEOUT
`timescale 1ns/1ps
module cnn_watchdog #(
  parameter int unsigned TIMEOUT = cnn_pkg::DefTimeout,
  parameter int unsigned CW      = cnn_pkg::DefCw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_clear,
  input  logic          i_run,
  output logic [CW-1:0] o_count,
  output logic          o_expired
);

  localparam logic [CW-1:0] CntMax     = '1;
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;

  // Start wins over clear so a frame that begins and is immediately counted
  // never loses its first cycle.
  always_comb begin
    w_cnt_d = r_cnt;
    if (i_start) begin
      w_cnt_d = CW'(1);
    end else if (i_clear) begin
      w_cnt_d = '0;
    end else if (i_run && (r_cnt != CntMax)) begin
      w_cnt_d = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_count   = r_cnt;
  assign o_expired = (r_cnt == TimeoutVal);

endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame controller in front of a CNN inference core.
// Accepts FRAME_PIXELS pixels from an upstream valid/ready source, forwards
// them to the CNN with one cycle of latency, waits for the CNN decision and
// reports it as a one-cycle result strobe. A watchdog reports 4'hF if the
// result does not arrive within TIMEOUT cycles of the first pixel.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   src_valid/src_ready/src_data  : upstream pixel stream
//   abort                         : synchronous frame abort
//   cnn_data/cnn_valid            : pixel stream into the CNN
//   cnn_busy/cnn_valid_out        : CNN status and result strobe
//   cnn_decision                  : CNN class output
//   cnn_en                        : CNN datapath clock-gate enable
//   res_valid/res_decision        : result strobe and class (held)
//   res_timeout/res_cycles        : watchdog flag and frame latency (held)
//   frame_cnt                     : completed frames, timeouts included
`timescale 1ns/1ps
module cnn_frame_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = DefFramePixels,
  parameter int unsigned TIMEOUT      = DefTimeout,
  parameter int unsigned CW           = DefCw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic [7:0]    src_data,
  input  logic          abort,
  output logic [7:0]    cnn_data,
  output logic          cnn_valid,
  input  logic          cnn_busy,
  input  logic          cnn_valid_out,
  input  logic [3:0]    cnn_decision,
  output logic          cnn_en,
  output logic          res_valid,
  output logic [3:0]    res_decision,
  output logic          res_timeout,
  output logic [CW-1:0] res_cycles,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned   PW         = $clog2(FRAME_PIXELS + 1);
  localparam logic [PW-1:0] LastPix    = PW'(FRAME_PIXELS);
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);

  frame_state_e  r_state, w_state_d;
  logic [PW-1:0] r_pix_cnt, w_pix_cnt_d;

  logic [7:0]    r_cnn_data;
  logic          r_cnn_valid;

  logic          r_res_valid, w_res_valid_d;
  logic [3:0]    r_res_decision, w_res_decision_d;
  logic          r_res_timeout, w_res_timeout_d;
  logic [CW-1:0] r_res_cycles, w_res_cycles_d;
  logic [15:0]   r_frame_cnt, w_frame_cnt_d;

  logic          w_src_ready;
  logic          w_xfer;
  logic          w_accept;
  logic          w_fin_ok;
  logic          w_fin_to;
  logic          w_start;
  logic          w_clear;
  logic          w_run;
  logic [CW-1:0] w_count;
  logic          w_wd_expired;
  logic          w_expired;

  // Ready is purely a function of state (and CNN busy while idle).
  always_comb begin
    w_src_ready = 1'b0;
    unique case (r_state)
      StIdle:  w_src_ready = ~cnn_busy;
      StLoad:  w_src_ready = 1'b1;
      default: w_src_ready = 1'b0;
    endcase
  end

  assign w_xfer   = src_valid & w_src_ready;
  // An aborted cycle's handshake still completes upstream but the pixel is
  // not forwarded to the CNN.
  assign w_accept = w_xfer & ~abort;

  assign w_expired = w_wd_expired & (r_state != StIdle);

  always_comb begin
    w_state_d        = r_state;
    w_pix_cnt_d      = r_pix_cnt;
    w_res_valid_d    = 1'b0;
    w_res_decision_d = r_res_decision;
    w_res_timeout_d  = r_res_timeout;
    w_res_cycles_d   = r_res_cycles;
    w_frame_cnt_d    = r_frame_cnt;
    w_fin_ok         = 1'b0;
    w_fin_to         = 1'b0;
    w_start          = 1'b0;

    if (abort) begin
      w_state_d   = StIdle;
      w_pix_cnt_d = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_xfer) begin
            w_start     = 1'b1;
            w_pix_cnt_d = PW'(1);
            w_state_d   = (LastPix == PW'(1)) ? StWait : StLoad;
          end
        end
        StLoad: begin
          // CNN results are not expected while loading, only the watchdog ends it.
          if (w_expired) begin
            w_fin_to = 1'b1;
          end else if (w_xfer) begin
            w_pix_cnt_d = r_pix_cnt + PW'(1);
            if (r_pix_cnt + PW'(1) == LastPix) begin
              w_state_d = StWait;
            end
          end
        end
        StWait: begin
          // A real result coinciding with the timeout cycle takes precedence.
          if (cnn_valid_out) begin
            w_fin_ok = 1'b1;
          end else if (w_expired) begin
            w_fin_to = 1'b1;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase

      if (w_fin_ok || w_fin_to) begin
        w_state_d        = StIdle;
        w_pix_cnt_d      = '0;
        w_res_valid_d    = 1'b1;
        w_res_decision_d = w_fin_ok ? cnn_decision : TimeoutCode;
        w_res_timeout_d  = w_fin_to;
        w_res_cycles_d   = w_fin_ok ? w_count : TimeoutVal;
        w_frame_cnt_d    = r_frame_cnt + 16'd1;
      end
    end
  end

  assign w_clear = (w_state_d == StIdle);
  assign w_run   = (r_state != StIdle);

  cnn_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_clear   (w_clear),
    .i_run     (w_run),
    .o_count   (w_count),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_pix_cnt      <= '0;
      r_cnn_data     <= '0;
      r_cnn_valid    <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_decision <= '0;
      r_res_timeout  <= 1'b0;
      r_res_cycles   <= '0;
      r_frame_cnt    <= '0;
    end else begin
      r_state        <= w_state_d;
      r_pix_cnt      <= w_pix_cnt_d;
      r_cnn_valid    <= w_accept;
      if (w_accept) begin
        r_cnn_data <= src_data;
      end
      r_res_valid    <= w_res_valid_d;
      r_res_decision <= w_res_decision_d;
      r_res_timeout  <= w_res_timeout_d;
      r_res_cycles   <= w_res_cycles_d;
      r_frame_cnt    <= w_frame_cnt_d;
    end
  end

  assign src_ready    = w_src_ready;
  assign cnn_data     = r_cnn_data;
  assign cnn_valid    = r_cnn_valid;
  assign cnn_en       = (r_state != StIdle) | cnn_busy | r_cnn_valid;
  assign res_valid    = r_res_valid;
  assign res_decision = r_res_decision;
  assign res_timeout  = r_res_timeout;
  assign res_cycles   = r_res_cycles;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Self-checking bench for cnn_frame_ctrl (784-pixel frames, TIMEOUT 2000).
`timescale 1ns/1ps
module tb_cnn_frame_ctrl;

  localparam int unsigned FramePixels = 784;
  localparam int unsigned Timeout     = 2000;
  localparam int unsigned Cw          = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [7:0]    src_data = 8'h00;
  logic          abort = 1'b0;
  logic [7:0]    cnn_data;
  logic          cnn_valid;
  logic          cnn_busy = 1'b0;
  logic          cnn_valid_out = 1'b0;
  logic [3:0]    cnn_decision = 4'h0;
  logic          cnn_en;
  logic          res_valid;
  logic [3:0]    res_decision;
  logic          res_timeout;
  logic [Cw-1:0] res_cycles;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  cnn_frame_ctrl #(
    .FRAME_PIXELS (FramePixels),
    .TIMEOUT      (Timeout),
    .CW           (Cw)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_data      (src_data),
    .abort         (abort),
    .cnn_data      (cnn_data),
    .cnn_valid     (cnn_valid),
    .cnn_busy      (cnn_busy),
    .cnn_valid_out (cnn_valid_out),
    .cnn_decision  (cnn_decision),
    .cnn_en        (cnn_en),
    .res_valid     (res_valid),
    .res_decision  (res_decision),
    .res_timeout   (res_timeout),
    .res_cycles    (res_cycles),
    .frame_cnt     (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic busy;
    logic vo;
    logic sv;
    logic exp_ready;
    logic exp_en;
  } idle_vec_t;

  idle_vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Streams n pixels (every other cycle when gap is set) and checks that each
  // transfer reappears on cnn_valid/cnn_data exactly one cycle later.
  // Returns at the negedge following the last accepting edge.
  task automatic load_frame(input int n, input bit gap, output int mism, output int pulses);
    int         idx;
    int         cyc;
    logic       prev_x;
    logic [7:0] prev_d;
    idx    = 0;
    cyc    = 0;
    prev_x = 1'b0;
    prev_d = 8'h00;
    mism   = 0;
    pulses = 0;
    @(posedge clk); #1;
    while (idx < n && cyc < 4 * n + 10) begin
      src_valid = gap ? ~cyc[0] : 1'b1;
      src_data  = 8'(idx * 7 + 3);
      @(negedge clk);
      if (cnn_valid !== prev_x) mism++;
      if (prev_x && (cnn_data !== prev_d)) mism++;
      if (cnn_valid === 1'b1) pulses++;
      prev_x = src_valid & src_ready;
      prev_d = src_data;
      if (prev_x) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    src_valid = 1'b0;
    @(negedge clk);
    if (cnn_valid !== prev_x) mism++;
    if (prev_x && (cnn_data !== prev_d)) mism++;
    if (cnn_valid === 1'b1) pulses++;
    if (idx != n) mism++;
  endtask

  // Drives a one-cycle CNN result after 'delay' rising edges; returns at the
  // negedge after the capturing edge.
  task automatic pulse_vo(input int delay, input logic [3:0] dec);
    repeat (delay) @(posedge clk);
    #1;
    cnn_valid_out = 1'b1;
    cnn_decision  = dec;
    @(posedge clk); #1;
    cnn_valid_out = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int m;
    int p;
    int cyc;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset values
    #12;
    chk("rst_cnn_valid", 32'(cnn_valid), 32'd0);
    chk("rst_cnn_data", 32'(cnn_data), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_dec", 32'(res_decision), 32'd0);
    chk("rst_res_to", 32'(res_timeout), 32'd0);
    chk("rst_res_cyc", 32'(res_cycles), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_cnn_en", 32'(cnn_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(src_ready), 32'd1);

    // Idle behaviour table: ready/enable follow busy, valid_out is ignored
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cnn_busy      = tbl[i].busy;
      cnn_valid_out = tbl[i].vo;
      src_valid     = tbl[i].sv;
      cnn_decision  = 4'h9;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(src_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_en", i), 32'(cnn_en), 32'(tbl[i].exp_en));
      @(posedge clk); #1;
      cnn_valid_out = 1'b0;
      src_valid     = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_res_valid", i), 32'(res_valid), 32'd0);
      chk($sformatf("tbl%0d_cnn_valid", i), 32'(cnn_valid), 32'd0);
    end
    cnn_busy = 1'b0;
    chk("tbl_frame_cnt", 32'(frame_cnt), 32'd0);

    // Normal frame, result 500 cycles after last pixel
    load_frame(FramePixels, 1'b0, m, p);
    chk("norm_mirror", 32'(m), 32'd0);
    chk("norm_pulses", 32'(p), 32'd784);
    chk("norm_wait_ready", 32'(src_ready), 32'd0);
    pulse_vo(500, 4'd3);
    chk("norm_res_valid", 32'(res_valid), 32'd1);
    chk("norm_res_dec", 32'(res_decision), 32'd3);
    chk("norm_res_to", 32'(res_timeout), 32'd0);
    chk("norm_res_cyc", 32'(res_cycles), 32'd1284);
    chk("norm_frame_cnt", 32'(frame_cnt), 32'd1);
    @(negedge clk);
    chk("norm_strobe_1cyc", 32'(res_valid), 32'd0);
    chk("norm_idle_ready", 32'(src_ready), 32'd1);

    // Abort at pixel 400, the aborted-cycle pixel is dropped
    load_frame(400, 1'b0, m, p);
    chk("abort_mirror", 32'(m), 32'd0);
    src_valid = 1'b1;
    src_data  = 8'hAA;
    abort     = 1'b1;
    #1;
    chk("abort_load_ready", 32'(src_ready), 32'd1);
    @(posedge clk); #1;
    abort     = 1'b0;
    src_valid = 1'b0;
    @(negedge clk);
    chk("abort_drop_pixel", 32'(cnn_valid), 32'd0);
    chk("abort_idle_en", 32'(cnn_en), 32'd0);
    pulse_vo(3, 4'd6);
    chk("abort_no_result", 32'(res_valid), 32'd0);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("hold_res_dec", 32'(res_decision), 32'd3);
    chk("hold_res_cyc", 32'(res_cycles), 32'd1284);
    load_frame(FramePixels, 1'b0, m, p);
    chk("after_abort_pulses", 32'(p), 32'd784);
    pulse_vo(100, 4'd4);
    chk("after_abort_valid", 32'(res_valid), 32'd1);
    chk("after_abort_dec", 32'(res_decision), 32'd4);
    chk("after_abort_cyc", 32'(res_cycles), 32'd884);
    chk("after_abort_cnt", 32'(frame_cnt), 32'd2);

    // Gapped input
    load_frame(FramePixels, 1'b1, m, p);
    chk("gap_mirror", 32'(m), 32'd0);
    chk("gap_pulses", 32'(p), 32'd784);
    chk("gap_ready_after", 32'(src_ready), 32'd0);
    pulse_vo(10, 4'd5);
    chk("gap_res_cyc", 32'(res_cycles), 32'd1577);
    chk("gap_frame_cnt", 32'(frame_cnt), 32'd3);

    // Watchdog timeout with the CNN busy
    load_frame(FramePixels, 1'b0, m, p);
    cnn_busy = 1'b1;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("to_latency", 32'(cyc), 32'd1217);
    chk("to_res_dec", 32'(res_decision), 32'hF);
    chk("to_res_to", 32'(res_timeout), 32'd1);
    chk("to_res_cyc", 32'(res_cycles), 32'd2000);
    chk("to_frame_cnt", 32'(frame_cnt), 32'd4);
    @(negedge clk);
    chk("to_strobe_1cyc", 32'(res_valid), 32'd0);
    chk("to_busy_ready", 32'(src_ready), 32'd0);
    chk("to_busy_en", 32'(cnn_en), 32'd1);
    repeat (3) @(negedge clk);
    chk("to_busy_ready_hold", 32'(src_ready), 32'd0);
    cnn_busy = 1'b0;
    #1;
    chk("to_busy_fall_ready", 32'(src_ready), 32'd1);

    // Result on exactly the timeout cycle
    load_frame(FramePixels, 1'b0, m, p);
    pulse_vo(1216, 4'd7);
    chk("coll_res_valid", 32'(res_valid), 32'd1);
    chk("coll_res_to", 32'(res_timeout), 32'd0);
    chk("coll_res_dec", 32'(res_decision), 32'd7);
    chk("coll_res_cyc", 32'(res_cycles), 32'd2000);
    chk("coll_frame_cnt", 32'(frame_cnt), 32'd5);

    // Asynchronous reset mid-WAIT
    load_frame(FramePixels, 1'b0, m, p);
    chk("rstw_in_wait", 32'(src_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_res_dec", 32'(res_decision), 32'd0);
    chk("rstw_res_cyc", 32'(res_cycles), 32'd0);
    chk("rstw_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rstw_cnn_en", 32'(cnn_en), 32'd0);
    chk("rstw_cnn_data", 32'(cnn_data), 32'd0);
    chk("rstw_ready", 32'(src_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    pulse_vo(5, 4'd9);
    chk("rstw_vo_ignored", 32'(res_valid), 32'd0);
    chk("rstw_cnt_after", 32'(frame_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_frame_ctrl.md
CNN_FRAME_CTRL -- requirements
Module: cnn_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 784: pixels per frame (28x28).
REQ-002 SHALL have parameter TIMEOUT, default 100000: maximum cycles from the first pixel to a result.
REQ-003 SHALL have parameter CW, default 20: width of the cycle counter.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port src_valid, input, 1: upstream pixel valid.
REQ-007 SHALL have port src_ready, output, 1: controller accepts a pixel this cycle.
REQ-008 SHALL have port src_data, input, 8: upstream pixel.
REQ-009 SHALL have port abort, input, 1: synchronous frame abort.
REQ-010 SHALL have port cnn_data, output, 8: pixel to cnn_top_opt data_in.
REQ-011 SHALL have port cnn_valid, output, 1: to cnn_top_opt valid_in.
REQ-012 SHALL have port cnn_busy, input, 1: from cnn_top_opt busy.
REQ-013 SHALL have port cnn_valid_out, input, 1: from cnn_top_opt valid_out.
REQ-014 SHALL have port cnn_decision, input, 4: from cnn_top_opt decision.
REQ-015 SHALL have port cnn_en, output, 1: clock-gate enable for the CNN datapath (energy saving).
REQ-016 SHALL have port res_valid, output, 1: one-cycle result strobe.
REQ-017 SHALL have port res_decision, output, 4: captured class, or 4'hF on timeout.
REQ-018 SHALL have port res_timeout, output, 1: result produced by the watchdog.
REQ-019 SHALL have port res_cycles, output, CW: cycles from first pixel accept to result.
REQ-020 SHALL have port frame_cnt, output, 16: completed frames, including timeouts.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, WAIT.
REQ-022 SHALL drive src_ready = ~cnn_busy in IDLE, 1 in LOAD, and 0 in WAIT.
REQ-023 SHALL transfer a pixel when src_valid & src_ready, and register it so that cnn_data/cnn_valid appear the next cycle (1-cycle latency); cnn_valid SHALL be 0 in cycles with no transfer, and gaps in src_valid SHALL be allowed.
REQ-024 SHALL, on a transfer in IDLE, go to LOAD with pix_cnt=1 and res_cycles counter=1.
REQ-025 SHALL, on the transfer that makes pix_cnt==FRAME_PIXELS, go to WAIT; no pixel beyond FRAME_PIXELS SHALL be accepted.
REQ-026 SHALL increment the cycle counter every cycle in LOAD and WAIT, saturating at 2^CW-1.
REQ-027 SHALL, when cnn_valid_out is seen in WAIT, register res_decision=cnn_decision, res_timeout=0, res_cycles=counter, pulse res_valid for 1 cycle, increment frame_cnt (wrapping 16'hFFFF->0), and go to IDLE.
REQ-028 SHALL, when the counter reaches TIMEOUT in LOAD or WAIT without cnn_valid_out, produce a result with res_decision=4'hF, res_timeout=1, and res_cycles=TIMEOUT, then go to IDLE.
REQ-029 SHALL let cnn_valid_out win when it coincides with the timeout cycle (normal result).
REQ-030 SHALL ignore cnn_valid_out in IDLE or LOAD, with no res_valid.
REQ-031 SHALL, on abort, go to IDLE next cycle from any state, suppress any pending result, leave frame_cnt unchanged, and drop a same-cycle transfer; abort SHALL take priority over cnn_valid_out and timeout.
REQ-032 SHALL drive cnn_en = (state!=IDLE) | cnn_busy | cnn_valid.
REQ-033 SHALL hold res_decision, res_timeout and res_cycles until the next result.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously force state=IDLE, pix_cnt=0, the counter=0, cnn_valid=0, cnn_data=0, res_valid=0, res_decision=0, res_timeout=0, res_cycles=0, and frame_cnt=0.
REQ-035 SHALL, after reset release, derive src_ready combinationally per REQ-022, so src_ready is 1 when cnn_busy=0.
REQ-036 SHALL, on reset mid-frame, discard the frame with no result strobe.

Structure
REQ-037 SHALL place the state enum, the default FRAME_PIXELS/TIMEOUT/CW constants and the 4'hF timeout code in the shared package cnn_pkg.
REQ-038 SHALL factor the saturating cycle counter and timeout compare into one sub-module, cnn_watchdog; the FSM and pixel register SHALL stay in cnn_frame_ctrl.

Verification
REQ-039 SHALL verify normal frame: 784 back-to-back pixels, with the DUT model asserting valid_out with decision=3 at 500 cycles after the last pixel -> one res_valid, res_decision=3, res_cycles=1284, frame_cnt=1.
REQ-040 SHALL verify gapped input: src_valid low every other cycle -> cnn_valid mirrors transfers delayed 1 cycle, exactly 784 cnn_valid pulses, src_ready=0 after the 784th.
REQ-041 SHALL verify timeout: TIMEOUT=2000 and no valid_out -> res_valid at counter 2000, res_decision=4'hF, res_timeout=1; with busy held high, src_ready stays 0 until busy falls.
REQ-042 SHALL verify collision: valid_out on exactly the timeout cycle -> res_timeout=0 and the captured decision is reported.
REQ-043 SHALL verify abort: abort at pixel 400 -> IDLE, no res_valid, frame_cnt unchanged; the next full frame completes normally.
REQ-044 SHALL verify async reset: rst_n low for 3 ns mid-WAIT -> all outputs zero immediately, and a valid_out arriving later is ignored.
